// File: rtl/fubr_multi_pkg.sv
// Shared encodings for the multi-port branch resolution unit: branch type,
// conditional subtype and redirect FSM state.
package fubr_multi_pkg;

  localparam logic [2:0] BRANCH_TYPE_NONE = 3'd0;
  localparam logic [2:0] BRANCH_TYPE_COND = 3'd1;
  localparam logic [2:0] BRANCH_TYPE_JAL  = 3'd2;
  localparam logic [2:0] BRANCH_TYPE_JALR = 3'd3;

  localparam logic [2:0] BRANCH_SUBOP_EQ  = 3'd0;
  localparam logic [2:0] BRANCH_SUBOP_NE  = 3'd1;
  localparam logic [2:0] BRANCH_SUBOP_LT  = 3'd2;
  localparam logic [2:0] BRANCH_SUBOP_GE  = 3'd3;
  localparam logic [2:0] BRANCH_SUBOP_LTU = 3'd4;
  localparam logic [2:0] BRANCH_SUBOP_GEU = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } redir_state_e;

endpackage

// File: rtl/fubr_multi_if.sv
// Issue, result, response and redirect signals of the multi-port branch unit.
// The slave modport is the branch unit; the master modport is its environment.
interface fubr_multi_if #(
  parameter int NUM_PORTS   = 2,
  parameter int XLEN        = 64,
  parameter int ROB_IDX_W   = 6,
  parameter int SPEC_STATES = 4
);

  logic                             flush;
  logic                             kill_en;
  logic [SPEC_STATES-1:0]           kill_mask;
  logic [ROB_IDX_W-1:0]             rob_head;

  logic [NUM_PORTS-1:0]             in_valid;
  logic [NUM_PORTS*XLEN-1:0]        in_pc;
  logic [NUM_PORTS*XLEN-1:0]        in_op1;
  logic [NUM_PORTS*XLEN-1:0]        in_op2;
  logic [NUM_PORTS*XLEN-1:0]        in_imm;
  logic [NUM_PORTS*XLEN-1:0]        in_pred_target;
  logic [NUM_PORTS*3-1:0]           in_br_type;
  logic [NUM_PORTS*3-1:0]           in_br_sub;
  logic [NUM_PORTS-1:0]             in_pred_taken;
  logic [NUM_PORTS-1:0]             in_is_jal;
  logic [NUM_PORTS-1:0]             in_is_jalr;
  logic [NUM_PORTS-1:0]             in_is_16bit;
  logic [NUM_PORTS*SPEC_STATES-1:0] in_spectag;
  logic [NUM_PORTS*SPEC_STATES-1:0] in_killmask;
  logic [NUM_PORTS*ROB_IDX_W-1:0]   in_rob_idx;

  logic [NUM_PORTS-1:0]             res_valid;
  logic [NUM_PORTS*XLEN-1:0]        res_value;

  logic [NUM_PORTS-1:0]             rsp_valid;
  logic [NUM_PORTS-1:0]             rsp_taken;
  logic [NUM_PORTS-1:0]             rsp_mispred;
  logic [NUM_PORTS-1:0]             rsp_isspec;
  logic [NUM_PORTS*XLEN-1:0]        rsp_target;

  logic                             redir_valid;
  logic                             redir_ready;
  logic [XLEN-1:0]                  redir_pc;
  logic [SPEC_STATES-1:0]           redir_spectag;
  logic [ROB_IDX_W-1:0]             redir_rob_idx;

  modport master (
    output flush, kill_en, kill_mask, rob_head,
    output in_valid, in_pc, in_op1, in_op2, in_imm, in_pred_target,
    output in_br_type, in_br_sub, in_pred_taken, in_is_jal, in_is_jalr,
    output in_is_16bit, in_spectag, in_killmask, in_rob_idx,
    input  res_valid, res_value,
    input  rsp_valid, rsp_taken, rsp_mispred, rsp_isspec, rsp_target,
    input  redir_valid, redir_pc, redir_spectag, redir_rob_idx,
    output redir_ready
  );

  modport slave (
    input  flush, kill_en, kill_mask, rob_head,
    input  in_valid, in_pc, in_op1, in_op2, in_imm, in_pred_target,
    input  in_br_type, in_br_sub, in_pred_taken, in_is_jal, in_is_jalr,
    input  in_is_16bit, in_spectag, in_killmask, in_rob_idx,
    output res_valid, res_value,
    output rsp_valid, rsp_taken, rsp_mispred, rsp_isspec, rsp_target,
    output redir_valid, redir_pc, redir_spectag, redir_rob_idx,
    input  redir_ready
  );

endinterface

// File: rtl/fubr_multi_br_resolve_lane.sv
// One branch resolution lane: purely combinational taken / target /
// mispredict / speculative / return-address evaluation for a single uop.
module br_resolve_lane
  import fubr_multi_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pred_target,
  input  logic [2:0]      br_type,
  input  logic [2:0]      br_sub,
  input  logic            pred_taken,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_16bit,
  output logic            taken,
  output logic            mispred,
  output logic            isspec,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] ret_addr
);

  logic signed [XLEN-1:0] op1_s;
  logic signed [XLEN-1:0] op2_s;
  logic                   is_cond;
  logic                   cond_taken;
  logic [XLEN-1:0]        link_addr;
  logic [XLEN-1:0]        target_raw;

  assign op1_s   = op1;
  assign op2_s   = op2;
  assign is_cond = (br_type == BRANCH_TYPE_COND);

  // Conditional outcome; unknown subtypes resolve not-taken
  always_comb begin
    cond_taken = 1'b0;
    case (br_sub)
      BRANCH_SUBOP_EQ:  cond_taken = (op1 == op2);
      BRANCH_SUBOP_NE:  cond_taken = (op1 != op2);
      BRANCH_SUBOP_LT:  cond_taken = (op1_s < op2_s);
      BRANCH_SUBOP_GE:  cond_taken = (op1_s >= op2_s);
      BRANCH_SUBOP_LTU: cond_taken = (op1 < op2);
      BRANCH_SUBOP_GEU: cond_taken = (op1 >= op2);
      default:          cond_taken = 1'b0;
    endcase
  end

  // Direction, target and return address; JAL is the only non-speculative branch
  always_comb begin
    taken      = is_jal | is_jalr | (is_cond & cond_taken);
    isspec     = is_jalr | (~is_jal & is_cond);
    link_addr  = pc + (is_16bit ? XLEN'(2) : XLEN'(4));
    target_raw = taken ? ((is_jalr ? op1 : pc) + imm) : link_addr;
    target     = {target_raw[XLEN-1:1], 1'b0};
    mispred    = (taken != pred_taken) | (target != pred_target);
    ret_addr   = (is_jal | is_jalr) ? link_addr : '0;
  end

endmodule

// File: rtl/fubr_multi.sv
// Multi-port branch resolution unit: resolves NUM_PORTS branches per cycle,
// registers per-port responses and keeps the oldest speculative mispredict
// in a redirect register until the frontend accepts it.
module fubr_multi
  import fubr_multi_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int XLEN        = 64,
  parameter int ROB_IDX_W   = 6,
  parameter int SPEC_STATES = 4
) (
  input logic       clk,
  input logic       rst,
  fubr_multi_if.slave bus
);

  // ROB age relative to head; the modulo wrap of the subtraction is intended
  function automatic logic [ROB_IDX_W-1:0] rob_age(
    input logic [ROB_IDX_W-1:0] idx,
    input logic [ROB_IDX_W-1:0] head
  );
    return idx - head;
  endfunction

  logic [NUM_PORTS-1:0] lane_taken;
  logic [NUM_PORTS-1:0] lane_mispred;
  logic [NUM_PORTS-1:0] lane_isspec;
  logic [XLEN-1:0]      lane_target [NUM_PORTS];
  logic [XLEN-1:0]      lane_ret    [NUM_PORTS];
  logic [ROB_IDX_W-1:0] lane_age    [NUM_PORTS];
  logic [NUM_PORTS-1:0] kill_hit;
  logic [NUM_PORTS-1:0] live;

  logic [NUM_PORTS*XLEN-1:0] res_value_c;

  logic [NUM_PORTS-1:0]      rsp_valid_p1;
  logic [NUM_PORTS-1:0]      rsp_taken_p1;
  logic [NUM_PORTS-1:0]      rsp_mispred_p1;
  logic [NUM_PORTS-1:0]      rsp_isspec_p1;
  logic [NUM_PORTS*XLEN-1:0] rsp_target_p1;

  logic                   cand_valid;
  logic [ROB_IDX_W-1:0]   cand_age;
  logic [XLEN-1:0]        cand_pc;
  logic [SPEC_STATES-1:0] cand_spectag;
  logic [SPEC_STATES-1:0] cand_killmask;
  logic [ROB_IDX_W-1:0]   cand_rob_idx;

  redir_state_e           state_q;
  redir_state_e           state_d;
  logic                   capture;
  logic [XLEN-1:0]        held_pc_q;
  logic [SPEC_STATES-1:0] held_spectag_q;
  logic [SPEC_STATES-1:0] held_killmask_q;
  logic [ROB_IDX_W-1:0]   held_rob_idx_q;
  logic [ROB_IDX_W-1:0]   held_age;
  logic                   held_killed;

  logic                   redir_valid_c;
  logic [XLEN-1:0]        redir_pc_c;
  logic [SPEC_STATES-1:0] redir_spectag_c;
  logic [ROB_IDX_W-1:0]   redir_rob_idx_c;

  // ---- stage p0: per-port combinational resolution ----
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    br_resolve_lane #(
      .XLEN(XLEN)
    ) u_lane (
      .pc          (bus.in_pc[g*XLEN +: XLEN]),
      .op1         (bus.in_op1[g*XLEN +: XLEN]),
      .op2         (bus.in_op2[g*XLEN +: XLEN]),
      .imm         (bus.in_imm[g*XLEN +: XLEN]),
      .pred_target (bus.in_pred_target[g*XLEN +: XLEN]),
      .br_type     (bus.in_br_type[g*3 +: 3]),
      .br_sub      (bus.in_br_sub[g*3 +: 3]),
      .pred_taken  (bus.in_pred_taken[g]),
      .is_jal      (bus.in_is_jal[g]),
      .is_jalr     (bus.in_is_jalr[g]),
      .is_16bit    (bus.in_is_16bit[g]),
      .taken       (lane_taken[g]),
      .mispred     (lane_mispred[g]),
      .isspec      (lane_isspec[g]),
      .target      (lane_target[g]),
      .ret_addr    (lane_ret[g])
    );

    assign kill_hit[g] = bus.kill_en &
                         (|(bus.in_killmask[g*SPEC_STATES +: SPEC_STATES] & bus.kill_mask));
    assign live[g]     = bus.in_valid[g] & ~rst & ~bus.flush & ~kill_hit[g];
    assign lane_age[g] = rob_age(bus.in_rob_idx[g*ROB_IDX_W +: ROB_IDX_W], bus.rob_head);
  end

  // Return addresses are only visible on live ports
  always_comb begin
    res_value_c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (live[i]) res_value_c[i*XLEN +: XLEN] = lane_ret[i];
    end
  end

  assign bus.res_valid = live;
  assign bus.res_value = res_value_c;

  // Oldest live speculative mispredict; strict compare lets the lower port win ties
  always_comb begin
    cand_valid    = 1'b0;
    cand_age      = '0;
    cand_pc       = '0;
    cand_spectag  = '0;
    cand_killmask = '0;
    cand_rob_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (live[i] && lane_mispred[i] && lane_isspec[i] &&
          (!cand_valid || (lane_age[i] < cand_age))) begin
        cand_valid    = 1'b1;
        cand_age      = lane_age[i];
        cand_pc       = lane_target[i];
        cand_spectag  = bus.in_spectag[i*SPEC_STATES +: SPEC_STATES];
        cand_killmask = bus.in_killmask[i*SPEC_STATES +: SPEC_STATES];
        cand_rob_idx  = bus.in_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      end
    end
  end

  // ---- stage p1: registered per-port responses ----
  // Responses are cleared on reset or flush; dead ports register zeros
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rsp_valid_p1   <= '0;
      rsp_taken_p1   <= '0;
      rsp_mispred_p1 <= '0;
      rsp_isspec_p1  <= '0;
      rsp_target_p1  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rsp_valid_p1[i]                  <= live[i];
        rsp_taken_p1[i]                  <= live[i] & lane_taken[i];
        rsp_mispred_p1[i]                <= live[i] & lane_mispred[i];
        rsp_isspec_p1[i]                 <= live[i] & lane_isspec[i];
        rsp_target_p1[i*XLEN +: XLEN]    <= live[i] ? lane_target[i] : '0;
      end
    end
  end

  assign bus.rsp_valid   = rsp_valid_p1;
  assign bus.rsp_taken   = rsp_taken_p1;
  assign bus.rsp_mispred = rsp_mispred_p1;
  assign bus.rsp_isspec  = rsp_isspec_p1;
  assign bus.rsp_target  = rsp_target_p1;

  // ---- redirect FSM ----
  assign held_age    = rob_age(held_rob_idx_q, bus.rob_head);
  assign held_killed = bus.kill_en & (|(held_killmask_q & bus.kill_mask));

  // State register; reset and flush both return to IDLE
  always_ff @(posedge clk) begin
    if (rst || bus.flush) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  // Next state and capture decision; an older candidate beats kill and accept
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cand_valid && (cand_age < held_age)) begin
          capture = 1'b1;
        end else if (held_killed) begin
          state_d = ST_IDLE;
        end else if (bus.redir_ready) begin
          if (cand_valid) capture = 1'b1;
          else            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Redirect payload register, loaded on capture
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      held_pc_q       <= '0;
      held_spectag_q  <= '0;
      held_killmask_q <= '0;
      held_rob_idx_q  <= '0;
    end else if (capture) begin
      held_pc_q       <= cand_pc;
      held_spectag_q  <= cand_spectag;
      held_killmask_q <= cand_killmask;
      held_rob_idx_q  <= cand_rob_idx;
    end
  end

  // Redirect outputs are driven only while a redirect is held
  always_comb begin
    redir_valid_c   = 1'b0;
    redir_pc_c      = '0;
    redir_spectag_c = '0;
    redir_rob_idx_c = '0;
    if (state_q == ST_HOLD) begin
      redir_valid_c   = 1'b1;
      redir_pc_c      = held_pc_q;
      redir_spectag_c = held_spectag_q;
      redir_rob_idx_c = held_rob_idx_q;
    end
  end

  assign bus.redir_valid   = redir_valid_c;
  assign bus.redir_pc      = redir_pc_c;
  assign bus.redir_spectag = redir_spectag_c;
  assign bus.redir_rob_idx = redir_rob_idx_c;

endmodule

// File: tb/tb_fubr_multi.sv
// Directed bench for fubr_multi: per-port resolution, age arbitration across
// the ROB wrap, redirect hold/replace/accept/kill, reset and flush.
module tb_fubr_multi;
  import fubr_multi_pkg::*;

  localparam int NP = 2;
  localparam int XL = 64;
  localparam int RW = 6;
  localparam int SS = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fubr_multi_if #(.NUM_PORTS(NP), .XLEN(XL), .ROB_IDX_W(RW), .SPEC_STATES(SS)) bus ();

  fubr_multi #(.NUM_PORTS(NP), .XLEN(XL), .ROB_IDX_W(RW), .SPEC_STATES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush          = 1'b0;
    bus.kill_en        = 1'b0;
    bus.kill_mask      = '0;
    bus.redir_ready    = 1'b0;
    bus.in_valid       = '0;
    bus.in_pc          = '0;
    bus.in_op1         = '0;
    bus.in_op2         = '0;
    bus.in_imm         = '0;
    bus.in_pred_target = '0;
    bus.in_br_type     = '0;
    bus.in_br_sub      = '0;
    bus.in_pred_taken  = '0;
    bus.in_is_jal      = '0;
    bus.in_is_jalr     = '0;
    bus.in_is_16bit    = '0;
    bus.in_spectag     = '0;
    bus.in_killmask    = '0;
    bus.in_rob_idx     = '0;
  endtask

  task automatic drive_port(input int p, input logic [2:0] typ, input logic [2:0] sub,
                            input logic jal, input logic jalr, input logic is16,
                            input logic pt, input logic [63:0] pc, input logic [63:0] op1,
                            input logic [63:0] op2, input logic [63:0] imm,
                            input logic [63:0] ptgt, input logic [3:0] tag,
                            input logic [3:0] km, input logic [5:0] rob);
    bus.in_valid[p]              = 1'b1;
    bus.in_br_type[p*3 +: 3]     = typ;
    bus.in_br_sub[p*3 +: 3]      = sub;
    bus.in_is_jal[p]             = jal;
    bus.in_is_jalr[p]            = jalr;
    bus.in_is_16bit[p]           = is16;
    bus.in_pred_taken[p]         = pt;
    bus.in_pc[p*64 +: 64]        = pc;
    bus.in_op1[p*64 +: 64]       = op1;
    bus.in_op2[p*64 +: 64]       = op2;
    bus.in_imm[p*64 +: 64]       = imm;
    bus.in_pred_target[p*64 +: 64] = ptgt;
    bus.in_spectag[p*4 +: 4]     = tag;
    bus.in_killmask[p*4 +: 4]    = km;
    bus.in_rob_idx[p*6 +: 6]     = rob;
  endtask

  // BEQ 1,2 predicted taken to pc+0x40: resolves not-taken to pc+4, a mispredict
  task automatic mp(input int p, input logic [63:0] pc, input logic [5:0] rob,
                    input logic [3:0] km);
    drive_port(p, BRANCH_TYPE_COND, BRANCH_SUBOP_EQ, 1'b0, 1'b0, 1'b0, 1'b1,
               pc, 64'd1, 64'd2, 64'h40, pc + 64'h40, 4'(1 << p), km, rob);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    bus.rob_head = 6'd0;

    // Reset: a valid JAL must not show through
    drive_port(0, BRANCH_TYPE_NONE, BRANCH_SUBOP_EQ, 1'b1, 1'b0, 1'b0, 1'b0,
               64'h40, 64'd0, 64'd0, 64'h10, 64'h0, 4'b0001, 4'b0000, 6'd1);
    tick();
    tick();
    check("rst_res_valid",   64'(bus.res_valid), 64'h0);
    check("rst_res_value",   bus.res_value[63:0], 64'h0);
    check("rst_rsp_valid",   64'(bus.rsp_valid), 64'h0);
    check("rst_redir_valid", 64'(bus.redir_valid), 64'h0);
    check("rst_redir_pc",    bus.redir_pc, 64'h0);
    rst = 1'b0;
    idle_inputs();
    tick();

    // BEQ taken, correctly predicted
    drive_port(0, BRANCH_TYPE_COND, BRANCH_SUBOP_EQ, 1'b0, 1'b0, 1'b0, 1'b1,
               64'h1000, 64'd5, 64'd5, 64'h40, 64'h1040, 4'b0001, 4'b0000, 6'd1);
    #1;
    check("beq_res_valid", 64'(bus.res_valid), 64'h1);
    check("beq_res_value", bus.res_value[63:0], 64'h0);
    tick();
    check("beq_rsp_valid",   64'(bus.rsp_valid), 64'h1);
    check("beq_rsp_taken",   64'(bus.rsp_taken), 64'h1);
    check("beq_rsp_target",  bus.rsp_target[63:0], 64'h1040);
    check("beq_rsp_mispred", 64'(bus.rsp_mispred), 64'h0);
    check("beq_rsp_isspec",  64'(bus.rsp_isspec), 64'h1);
    check("beq_redir_valid", 64'(bus.redir_valid), 64'h0);
    idle_inputs();

    // Signed vs unsigned compares with op1=-1, op2=1
    drive_port(0, BRANCH_TYPE_COND, BRANCH_SUBOP_LT, 1'b0, 1'b0, 1'b0, 1'b1,
               64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 64'h2010, 4'b0001, 4'b0, 6'd1);
    drive_port(1, BRANCH_TYPE_COND, BRANCH_SUBOP_LTU, 1'b0, 1'b0, 1'b0, 1'b0,
               64'h2100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 64'h2104, 4'b0010, 4'b0, 6'd2);
    tick();
    check("lt_ltu_taken",   64'(bus.rsp_taken), 64'h1);
    check("lt_ltu_mispred", 64'(bus.rsp_mispred), 64'h0);
    check("ltu_target",     bus.rsp_target[127:64], 64'h2104);
    idle_inputs();
    drive_port(0, BRANCH_TYPE_COND, BRANCH_SUBOP_GE, 1'b0, 1'b0, 1'b0, 1'b0,
               64'h2200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 64'h2204, 4'b0001, 4'b0, 6'd1);
    drive_port(1, BRANCH_TYPE_COND, BRANCH_SUBOP_GEU, 1'b0, 1'b0, 1'b0, 1'b1,
               64'h2300, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 64'h2310, 4'b0010, 4'b0, 6'd2);
    tick();
    check("ge_geu_taken",   64'(bus.rsp_taken), 64'h2);
    check("ge_geu_mispred", 64'(bus.rsp_mispred), 64'h0);
    idle_inputs();
    drive_port(0, BRANCH_TYPE_COND, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0,
               64'h2400, 64'd9, 64'd9, 64'h10, 64'h2404, 4'b0001, 4'b0, 6'd1);
    drive_port(1, BRANCH_TYPE_COND, BRANCH_SUBOP_NE, 1'b0, 1'b0, 1'b0, 1'b1,
               64'h2500, 64'd3, 64'd4, 64'h8, 64'h2508, 4'b0010, 4'b0, 6'd2);
    tick();
    check("unk_ne_taken",   64'(bus.rsp_taken), 64'h2);
    check("unk_ne_mispred", 64'(bus.rsp_mispred), 64'h0);
    check("unk_target",     bus.rsp_target[63:0], 64'h2404);
    idle_inputs();

    // Both ports mispredict across the ROB wrap: port1 (age 2) beats port0 (age 6)
    bus.rob_head = 6'd60;
    drive_port(0, BRANCH_TYPE_COND, BRANCH_SUBOP_NE, 1'b0, 1'b0, 1'b0, 1'b1,
               64'h3000, 64'd7, 64'd7, 64'h80, 64'h3080, 4'b0001, 4'b0000, 6'd2);
    drive_port(1, BRANCH_TYPE_JALR, BRANCH_SUBOP_EQ, 1'b0, 1'b1, 1'b0, 1'b1,
               64'h4000, 64'h2001, 64'd0, 64'd0, 64'h5000, 4'b0100, 4'b0000, 6'd62);
    #1;
    check("wrap_res_value1", bus.res_value[127:64], 64'h4004);
    check("wrap_res_value0", bus.res_value[63:0], 64'h0);
    tick();
    check("wrap_redir_valid", 64'(bus.redir_valid), 64'h1);
    check("wrap_redir_rob",   64'(bus.redir_rob_idx), 64'd62);
    check("wrap_redir_pc",    bus.redir_pc, 64'h2000);
    check("wrap_redir_tag",   64'(bus.redir_spectag), 64'h4);
    check("wrap_rsp_mispred", 64'(bus.rsp_mispred), 64'h3);
    check("wrap_rsp_target0", bus.rsp_target[63:0], 64'h3004);
    idle_inputs();
    bus.rob_head = 6'd0;
    bus.redir_ready = 1'b1;
    tick();
    check("wrap_accept_idle", 64'(bus.redir_valid), 64'h0);
    idle_inputs();

    // Replacement by an older candidate; a younger one is ignored
    mp(0, 64'h500, 6'd10, 4'b0000);
    tick();
    check("hold_rob10", 64'(bus.redir_rob_idx), 64'd10);
    check("hold_pc10",  bus.redir_pc, 64'h504);
    idle_inputs();
    mp(0, 64'h600, 6'd5, 4'b0000);
    tick();
    check("replace_rob5", 64'(bus.redir_rob_idx), 64'd5);
    check("replace_pc5",  bus.redir_pc, 64'h604);
    idle_inputs();
    mp(0, 64'h700, 6'd20, 4'b0000);
    tick();
    check("ignore_valid", 64'(bus.redir_valid), 64'h1);
    check("ignore_rob",   64'(bus.redir_rob_idx), 64'd5);
    check("ignore_pc",    bus.redir_pc, 64'h604);
    idle_inputs();

    // Accept with no candidate, then accept with a simultaneous younger candidate
    bus.redir_ready = 1'b1;
    tick();
    check("accept_idle", 64'(bus.redir_valid), 64'h0);
    idle_inputs();
    mp(0, 64'h800, 6'd8, 4'b0000);
    tick();
    check("hold_rob8", 64'(bus.redir_rob_idx), 64'd8);
    idle_inputs();
    bus.redir_ready = 1'b1;
    mp(0, 64'h900, 6'd30, 4'b0000);
    tick();
    check("accept_cap_valid", 64'(bus.redir_valid), 64'h1);
    check("accept_cap_rob",   64'(bus.redir_rob_idx), 64'd30);
    check("accept_cap_pc",    bus.redir_pc, 64'h904);
    idle_inputs();
    bus.redir_ready = 1'b1;
    tick();
    check("accept_idle2", 64'(bus.redir_valid), 64'h0);
    idle_inputs();

    // Kill of an issuing uop: port0 dies, port1 survives and is captured
    bus.kill_en = 1'b1;
    bus.kill_mask = 4'b0010;
    mp(0, 64'hA00, 6'd3, 4'b0010);
    mp(1, 64'hB00, 6'd4, 4'b0001);
    #1;
    check("kill_res_valid", 64'(bus.res_valid), 64'h2);
    tick();
    check("kill_rsp_valid", 64'(bus.rsp_valid), 64'h2);
    check("kill_redir_rob", 64'(bus.redir_rob_idx), 64'd4);
    check("kill_redir_pc",  bus.redir_pc, 64'hB04);
    idle_inputs();
    bus.redir_ready = 1'b1;
    tick();
    idle_inputs();

    // Kill of the held entry: non-matching mask keeps it, matching mask drops it
    mp(0, 64'hC00, 6'd12, 4'b0010);
    tick();
    check("kheld_valid", 64'(bus.redir_valid), 64'h1);
    idle_inputs();
    bus.kill_en = 1'b1;
    bus.kill_mask = 4'b0100;
    tick();
    check("kheld_miss", 64'(bus.redir_valid), 64'h1);
    bus.kill_mask = 4'b0010;
    tick();
    check("kheld_hit", 64'(bus.redir_valid), 64'h0);
    idle_inputs();

    // Reset in the middle of HOLD
    mp(0, 64'hD00, 6'd14, 4'b0000);
    tick();
    check("rsthold_valid", 64'(bus.redir_valid), 64'h1);
    rst = 1'b1;
    mp(1, 64'hD80, 6'd15, 4'b0000);
    tick();
    check("rsthold_redir_valid", 64'(bus.redir_valid), 64'h0);
    check("rsthold_redir_pc",    bus.redir_pc, 64'h0);
    check("rsthold_redir_rob",   64'(bus.redir_rob_idx), 64'h0);
    check("rsthold_rsp_valid",   64'(bus.rsp_valid), 64'h0);
    check("rsthold_rsp_target",  bus.rsp_target[63:0], 64'h0);
    rst = 1'b0;
    idle_inputs();
    tick();

    // Flush with both ports valid while holding
    mp(0, 64'hE00, 6'd16, 4'b0000);
    tick();
    check("flush_pre_valid", 64'(bus.redir_valid), 64'h1);
    idle_inputs();
    bus.flush = 1'b1;
    mp(0, 64'hE80, 6'd17, 4'b0000);
    mp(1, 64'hF00, 6'd18, 4'b0000);
    #1;
    check("flush_res_valid", 64'(bus.res_valid), 64'h0);
    tick();
    check("flush_redir_valid", 64'(bus.redir_valid), 64'h0);
    check("flush_redir_tag",   64'(bus.redir_spectag), 64'h0);
    check("flush_rsp_valid",   64'(bus.rsp_valid), 64'h0);
    check("flush_rsp_mispred", 64'(bus.rsp_mispred), 64'h0);
    check("flush_rsp_target1", bus.rsp_target[127:64], 64'h0);
    idle_inputs();
    tick();
    check("flush_idle", 64'(bus.redir_valid), 64'h0);

    // Compressed JAL after reset: return address pc+2, not speculative
    drive_port(0, BRANCH_TYPE_NONE, BRANCH_SUBOP_EQ, 1'b1, 1'b0, 1'b1, 1'b1,
               64'h100, 64'd0, 64'd0, 64'h20, 64'h120, 4'b0001, 4'b0000, 6'd1);
    #1;
    check("jal_res_valid", 64'(bus.res_valid), 64'h1);
    check("jal_res_value", bus.res_value[63:0], 64'h102);
    tick();
    check("jal_rsp_taken",   64'(bus.rsp_taken), 64'h1);
    check("jal_rsp_target",  bus.rsp_target[63:0], 64'h120);
    check("jal_rsp_mispred", 64'(bus.rsp_mispred), 64'h0);
    check("jal_rsp_isspec",  64'(bus.rsp_isspec), 64'h0);
    check("jal_redir_valid", 64'(bus.redir_valid), 64'h0);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fubr_multi.md
Name: fubr_multi

Overview:
- Multi-port branch resolution unit; successor to the single-port branch FU.
- Resolves NUM_PORTS branch/JAL/JALR uops per cycle and drives per-port result and wakeup data.
- Emits per-port registered resolve responses.
- Arbitrates all mispredictions to the oldest one (ROB age) and holds it in a redirect register until the frontend accepts it.

Parameters:
- NUM_PORTS, 2, branch issue ports resolved in parallel.
- XLEN, 64, operand/PC width.
- ROB_IDX_W, 6, ROB index width; age arithmetic is modulo 2^ROB_IDX_W.
- SPEC_STATES, 4, speculative tag/killmask width (one-hot tags).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush.
- kill_en  in  1  external kill strobe.
- kill_mask  in  SPEC_STATES  tags being killed.
- rob_head  in  ROB_IDX_W  oldest ROB entry, used for age.
- in_valid  in  NUM_PORTS  per-port uop valid.
- in_pc, in_op1, in_op2, in_imm, in_pred_target  in  NUM_PORTS*XLEN  flattened per-port operands.
- in_br_type  in  NUM_PORTS*3  branch type; COND=conditional.
- in_br_sub  in  NUM_PORTS*3  subtype EQ/NE/LT/GE/LTU/GEU.
- in_pred_taken, in_is_jal, in_is_jalr, in_is_16bit  in  NUM_PORTS  per-port flags.
- in_spectag, in_killmask  in  NUM_PORTS*SPEC_STATES  own tag; tags this uop depends on.
- in_rob_idx  in  NUM_PORTS*ROB_IDX_W  ROB index.
- res_valid  out  NUM_PORTS  combinational result valid.
- res_value  out  NUM_PORTS*XLEN  return address (PC+2/4 for JAL/JALR, else 0).
- rsp_valid, rsp_taken, rsp_mispred, rsp_isspec  out  NUM_PORTS  registered resolve response.
- rsp_target  out  NUM_PORTS*XLEN  registered actual target.
- redir_valid  out  1  redirect pending.
- redir_ready  in  1  frontend accepts redirect.
- redir_pc  out  XLEN  corrected fetch PC.
- redir_spectag  out  SPEC_STATES  tag of mispredicting branch.
- redir_rob_idx  out  ROB_IDX_W  ROB index of mispredicting branch.

Behaviour:
- Per-port resolution is combinational and matches the single-port rules:
  - COND: taken by subtype compare, signed/unsigned per subtype; unknown subtype gives not-taken.
  - JAL: taken, not speculative.
  - JALR: taken, speculative.
  - Taken target = (JALR ? op1 : pc) + imm; not-taken target = pc + (is_16bit ? 2 : 4).
  - Bit 0 of the actual target is forced to 0.
  - mispred = (taken != pred_taken) | (target != pred_target).
- A port is live when in_valid=1, rst=0, flush=0, and NOT (kill_en & |(in_killmask & kill_mask)).
  - res_valid is the port's live bit.
- rsp_*: one-cycle latency. Registered every cycle; non-live ports register all zeros.
- Age: age(i) = (rob_idx - rob_head) mod 2^ROB_IDX_W. Smaller is older.
  - Ties cannot occur; if they do, the lower port number wins.
- Candidate = oldest live port with mispred=1 and isspec=1.
- Redirect FSM has states IDLE and HOLD.
  - IDLE: a candidate is captured into the redirect register and the FSM goes to HOLD. redir_valid rises the next cycle.
  - HOLD: redir_valid=1 and the outputs are stable unless replaced. Replacement happens when a candidate's age < the held age, both computed against the current rob_head; candidates that are younger or equal are ignored.
  - HOLD with redir_ready=1 and no older candidate: go to IDLE. If a candidate arrives in the same cycle as the accept, capture it and stay in HOLD.
  - HOLD, held killed: held killmask & kill_mask non-zero with kill_en → IDLE, unless an older live candidate exists, which is then captured.
- flush or rst: synchronously clears FSM to IDLE and clears all rsp_* and redir_* outputs to 0. res_* outputs are 0 combinationally.
- Reset values: all registered outputs 0; FSM in IDLE.
- rob_head wrap: the modulo subtraction handles head > idx, e.g. head=62, idx=1 gives age 3.

Decomposition:
- Shared package/defines: branch type/subtype encodings (reuse existing BRANCH_TYPE_*/BRANCH_SUBOP_* defines) and FSM state encoding.
- Sub-module br_resolve_lane: one per port via generate. Pure combinational taken/target/mispred/isspec/return-address logic.
- Top holds: age arbiter, response registers, redirect FSM.

Test Plan:
- Port0 BEQ, op1=op2=5, pc=0x1000, imm=0x40, pred_taken=1, pred_target=0x1040 → next cycle rsp_taken=1, rsp_target=0x1040, rsp_mispred=0; redir_valid stays 0.
- Both ports mispredict, rob_head=60. Port0 rob=2 (age 6), BNE op1=op2, pred taken; port1 rob=62 (age 2) JALR op1=0x2001, imm=0 → redir_rob_idx=62, redir_pc=0x2000.
- HOLD with rob 10; next cycle a mispredict with rob 5 (head 0) arrives → replaced, redir_rob_idx=5. A later mispredict with rob 20 is ignored.
- HOLD with redir_ready=1 and no candidate → redir_valid=0 next cycle. Accept cycle with a simultaneous candidate → redir_valid stays 1 with the new rob_idx.
- kill_en=1, kill_mask=0010:
  - Issued uop with killmask 0010 → res_valid=0 and rsp_valid=0 next cycle.
  - Held entry with killmask 0010 → FSM returns to IDLE.
- rst asserted mid-HOLD, and separately flush asserted with in_valid=11 → next cycle all rsp_* and redir_* are 0 and FSM is IDLE. A JAL with is_16bit=1, pc=0x100 after reset gives res_value=0x102.
